// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI transfer master: FSM state encoding and
// default geometry used by the top and its phase divider.
package spi_xfer_pkg;

   localparam int DEF_MAX_BITS = 64;
   localparam int DEF_SS_W     = 8;
   localparam int DEF_DIV_W    = 16;
   localparam int DEF_LEN_W    = $clog2(DEF_MAX_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD  = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_TRAIL = 3'd4,
      S_DONE  = 3'd5
   } spi_state_t;

endpackage

// File: rtl/spi_xfer_master_half_div.sv
// Phase timer: reloads on every FSM state change and flags the last cycle of
// each sck half-period, so every phase lasts exactly load_i+1 cycles.
module spi_half_div
   import spi_xfer_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             restart_i,
   input  logic [DIV_W-1:0] load_i,
   output logic             end_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   // Next count: reload on restart, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i)
         cnt_d = load_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - DIV_W'(1);
   end

   // Counter register.
   always_ff @(posedge clock) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign end_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_master.sv
// Mode-0 SPI master: one request in, up to MAX_BITS bits exchanged MSB-first,
// received bits returned right-aligned over a response handshake.
module spi_xfer_master
   import spi_xfer_pkg::*;
#(
   parameter  int MAX_BITS = DEF_MAX_BITS,
   parameter  int SS_W     = DEF_SS_W,
   parameter  int DIV_W    = DEF_DIV_W,
   localparam int LEN_W    = $clog2(MAX_BITS + 1),
   localparam int SS_IW    = (SS_W > 1) ? $clog2(SS_W) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [MAX_BITS-1:0] req_data,
   input  logic [LEN_W-1:0]    req_len,
   input  logic [SS_IW-1:0]    req_ss,
   input  logic [DIV_W-1:0]    req_div,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [MAX_BITS-1:0] rsp_data,
   output logic                sck,
   output logic [SS_W-1:0]     ss,
   output logic                mosi,
   input  logic                miso
);

   spi_state_t          state_q, state_d;
   logic [MAX_BITS-1:0] tx_q, rx_q;
   logic [LEN_W-1:0]    bits_q;
   logic [SS_IW-1:0]    ss_idx_q;
   logic [DIV_W-1:0]    div_q;
   logic                ph_end, active, accept;
   logic [LEN_W-1:0]    len_c;

   assign accept = (state_q == S_IDLE) && req_valid;
   assign len_c  = (req_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : req_len;
   assign active = (state_q == S_LEAD) || (state_q == S_HIGH) ||
                   (state_q == S_LOW)  || (state_q == S_TRAIL);

   // The divider value is not latched yet on the accept edge, so take it
   // straight from the request while idle.
   spi_half_div #(.DIV_W(DIV_W)) u_div (
      .clock     (clock),
      .reset     (reset),
      .restart_i (state_d != state_q),
      .load_i    ((state_q == S_IDLE) ? req_div : div_q),
      .end_o     (ph_end)
   );

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = S_LEAD;
         end
         S_LEAD:  if (ph_end) state_d = (bits_q != '0) ? S_HIGH : S_TRAIL;
         S_HIGH:  if (ph_end) state_d = S_LOW;
         S_LOW:   if (ph_end) state_d = (bits_q != '0) ? S_HIGH : S_TRAIL;
         S_TRAIL: if (ph_end) state_d = S_DONE;
         S_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Datapath: the tx word is left-justified so the next bit is always the
   // MSB; a zero-length transfer loads all ones so mosi idles high.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_q     <= '0;
         rx_q     <= '0;
         bits_q   <= '0;
         ss_idx_q <= '0;
         div_q    <= '0;
      end else if (accept) begin
         tx_q     <= (len_c == '0) ? '1 : (req_data << (LEN_W'(MAX_BITS) - len_c));
         rx_q     <= '0;
         bits_q   <= len_c;
         ss_idx_q <= req_ss;
         div_q    <= req_div;
      end else begin
         if (state_q != S_HIGH && state_d == S_HIGH)
            rx_q <= {rx_q[MAX_BITS-2:0], miso};
         if (state_q == S_HIGH && state_d == S_LOW) begin
            bits_q <= bits_q - LEN_W'(1);
            // Keep the final bit on mosi once nothing is left to send.
            if (bits_q > LEN_W'(1)) tx_q <= tx_q << 1;
         end
      end
   end

   // Slave-select decode; an out-of-range index selects nothing.
   always_comb begin
      ss = '1;
      for (int i = 0; i < SS_W; i++)
         if (active && ss_idx_q == SS_IW'(i)) ss[i] = 1'b0;
   end

   assign sck      = (state_q == S_HIGH);
   assign mosi     = active ? tx_q[MAX_BITS-1] : 1'b1;
   assign rsp_data = rx_q;

endmodule

// File: tb/tb_spi_xfer_master.sv
// Randomized bench for spi_xfer_master with a bit-level reference model.
module tb_spi_xfer_master;

   localparam int MB = 64;
   localparam int SW = 6;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, rsp_valid, rsp_ready;
   logic [MB-1:0] req_data, rsp_data;
   logic [6:0]    req_len;
   logic [2:0]    req_ss;
   logic [DW-1:0] req_div;
   logic          sck, mosi, miso;
   logic [SW-1:0] ss;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   spi_xfer_master #(.MAX_BITS(MB), .SS_W(SW), .DIV_W(DW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .req_len(req_len), .req_ss(req_ss), .req_div(req_div),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic junk_req();
      req_data = rnd64();
      req_len  = 7'($urandom);
      req_ss   = 3'($urandom);
      req_div  = 16'($urandom);
   endtask

   // One full transfer: the model knows only the bit order and phase timing.
   task automatic xfer(input logic [63:0] data, input int len, input int ssi,
                       input int div, input bit lp, input logic [63:0] pat,
                       input int hold);
      int eff, p, n, nrise, t_done, ss_bad, mosi_bad, rise_bad, rdy_bad, hold_bad;
      logic [63:0] mask, exp_rx;
      logic [SW-1:0] exp_ss;
      logic prev_sck;
      eff = (len > MB) ? MB : len;
      p = div + 1;
      mask = '0;
      for (int i = 0; i < eff; i++) mask[i] = 1'b1;
      exp_rx = (lp ? data : pat) & mask;
      exp_ss = '1;
      if (ssi < SW) exp_ss[ssi] = 1'b0;

      @(negedge clock);
      req_valid = 1'b1;
      req_data  = data;
      req_len   = 7'(len);
      req_ss    = 3'(ssi);
      req_div   = 16'(div);
      miso      = 1'b0;
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
      @(posedge clock);
      #1;
      req_valid = 1'($urandom);
      junk_req();

      n = 0; nrise = 0; prev_sck = 1'b0; t_done = -1;
      ss_bad = 0; mosi_bad = 0; rise_bad = 0; rdy_bad = 0;
      while (n < 3000) begin
         @(negedge clock);
         if (rsp_valid) begin
            t_done = n;
            break;
         end
         if (sck && !prev_sck) begin
            if (n != (1 + 2 * nrise) * p) rise_bad++;
            nrise++;
         end
         if (ss !== exp_ss) ss_bad++;
         if (req_ready) rdy_bad++;
         if (!sck && nrise < eff && mosi !== data[eff-1-nrise]) mosi_bad++;
         miso = lp ? mosi : ((nrise < eff) ? pat[eff-1-nrise] : 1'($urandom));
         prev_sck = sck;
         n++;
      end
      chk("latency", 64'(t_done), 64'((2 * eff + 2) * p));
      chk("sck_rises", 64'(nrise), 64'(eff));
      chk("rise_timing", 64'(rise_bad), 64'd0);
      chk("ss_active", 64'(ss_bad), 64'd0);
      chk("mosi_bits", 64'(mosi_bad), 64'd0);
      chk("req_ready_busy", 64'(rdy_bad), 64'd0);
      chk("rsp_data", rsp_data, exp_rx);
      chk("done_pins", {59'd0, sck, mosi, 3'd0}, {59'd0, 1'b0, 1'b1, 3'd0});
      chk("done_ss", 64'(ss), 64'(6'h3F));

      hold_bad = 0;
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         req_valid = 1'b1;
         junk_req();
         @(negedge clock);
         if (!rsp_valid || rsp_data !== exp_rx || req_ready) hold_bad++;
      end
      if (hold > 0) chk("rsp_hold", 64'(hold_bad), 64'd0);
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge clock);
      rsp_ready = 1'b0;
      chk("release_idle", {62'd0, req_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});
   endtask

   initial begin
      int n, nrise;
      logic prev_sck;
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; miso = 1'b0;
      req_data = '0; req_len = '0; req_ss = '0; req_div = '0;
      repeat (3) @(negedge clock);
      chk("rst_pins", {58'd0, req_ready, rsp_valid, sck, mosi, 2'd0},
                      {58'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0});
      chk("rst_ss", 64'(ss), 64'(6'h3F));
      chk("rst_rsp_data", rsp_data, 64'd0);
      reset = 1'b0;

      xfer(64'hA5, 8, 2, 0, 1'b1, 64'd0, 0);
      xfer(rnd64(), 64, 0, 3, 1'b0, '1, 0);
      xfer(rnd64(), 0, 1, 1, 1'b0, rnd64(), 0);
      xfer(rnd64(), 12, 3, 1, 1'b1, 64'd0, 20);
      xfer(64'h5, 4, 6, 0, 1'b0, rnd64(), 0);
      xfer(rnd64(), 5, 7, 2, 1'b1, 64'd0, 0);
      xfer(rnd64(), 100, 4, 0, 1'b1, 64'd0, 1);
      xfer(rnd64(), 1, 5, 0, 1'b0, rnd64(), 0);

      // Reset during the HIGH phase of bit 3.
      @(negedge clock);
      req_valid = 1'b1; req_data = rnd64(); req_len = 7'd8; req_ss = 3'd1; req_div = 16'd2;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      n = 0; nrise = 0; prev_sck = 1'b0;
      while (n < 500 && nrise < 4) begin
         @(negedge clock);
         if (sck && !prev_sck) nrise++;
         prev_sck = sck;
         n++;
      end
      chk("rst_wait", 64'(nrise), 64'd4);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("midrst_pins", {58'd0, req_ready, rsp_valid, sck, mosi, 2'd0},
                         {58'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0});
      chk("midrst_ss", 64'(ss), 64'(6'h3F));
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 20; i++)
         xfer(rnd64(), int'($urandom_range(0, 70)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), 1'($urandom), rnd64(),
              int'($urandom_range(0, 3)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
